// File: rtl/nios2system_led_ctrl.sv
// rtl/nios2system_led_ctrl.sv - Avalon-MM LED controller: set/clear, blink prescaler, PWM dimming, registered outputs.
// Optional PWM stage enabled by defining NIOS2_LED_CTRL_PWM_EN.
module nios2system_led_ctrl #(
  parameter int WIDTH = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int PRESCALE_W = 24,
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_DUTY   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  logic                  wr_en;
  logic [WIDTH-1:0]      wd_bits;
  logic [WIDTH-1:0]      data;
  logic [WIDTH-1:0]      blink_mask;
  logic [PRESCALE_W-1:0] period;
  logic [PRESCALE_W-1:0] blink_cnt;
  logic                  blink_phase;
  logic                  pwm_on;
  logic [31:0]           duty_rd;
  logic [WIDTH-1:0]      gated;
  logic                  unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd_bits   = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data       <= RESET_VALUE;
      blink_mask <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:  data       <= wd_bits;
        ADDR_SET:   data       <= data | wd_bits;
        ADDR_CLEAR: data       <= data & ~wd_bits;
        ADDR_MASK:  blink_mask <= wd_bits;
        default:    ;
      endcase
    end
  end

  // A PERIOD write restarts the blink cycle and takes priority over terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period      <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wr_en && address == ADDR_PERIOD) begin
      period      <= writedata[PRESCALE_W-1:0];
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == period) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

`ifdef NIOS2_LED_CTRL_PWM_EN
  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty    <= '1;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (wr_en && address == ADDR_DUTY) begin
        duty <= writedata[PWM_W-1:0];
      end
    end
  end

  // All-ones duty is forced on so the reset default behaves like a plain PIO.
  assign pwm_on = (duty == '1) | (pwm_cnt < duty);

  always_comb begin
    duty_rd = '0;
    duty_rd[PWM_W-1:0] = duty;
  end
`else
  assign pwm_on  = 1'b1;
  assign duty_rd = '0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]      = data;
      ADDR_MASK:   readdata[WIDTH-1:0]      = blink_mask;
      ADDR_PERIOD: readdata[PRESCALE_W-1:0] = period;
      ADDR_DUTY:   readdata                 = duty_rd;
      ADDR_STATUS: readdata[1:0]            = {pwm_on, blink_phase};
      default:     readdata                 = '0;
    endcase
  end

  assign gated = data & (~blink_mask | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= '0;
    end else begin
      out_port <= gated;
    end
  end

endmodule

// File: tb/tb_nios2system_led_ctrl.sv
// tb/tb_nios2system_led_ctrl.sv - randomized bench for nios2system_led_ctrl against a cycle-count reference model.
module tb_nios2system_led_ctrl;

  localparam int W = 10;
  localparam logic [W-1:0] RV = 10'h2A5;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [W-1:0] out_port;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: registers plus edge counts since the last restart.
  logic [W-1:0] m_data, m_mask;
  longint       m_period;
  int           m_duty;
  longint       bk;
  longint       pk;
  logic [W-1:0] exp_out;

  nios2system_led_ctrl #(.WIDTH(W), .RESET_VALUE(RV), .PRESCALE_W(24), .PWM_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_phase();
    return ((bk / (m_period + 1)) % 2) == 0;
  endfunction

  function automatic bit m_pwm_on();
`ifdef NIOS2_LED_CTRL_PWM_EN
    return (m_duty == 255) || ((pk % 256) < m_duty);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [W-1:0] m_gated();
    logic [W-1:0] g;
    g = '0;
    for (int i = 0; i < W; i++)
      g[i] = m_data[i] & (!m_mask[i] || m_phase()) & m_pwm_on();
    return g;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_data);
      3'd3: return 32'(m_mask);
      3'd4: return 32'(m_period);
`ifdef NIOS2_LED_CTRL_PWM_EN
      3'd5: return 32'(m_duty);
`endif
      3'd6: return {30'd0, m_pwm_on(), m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_data = RV; m_mask = '0; m_period = 0; m_duty = 255; bk = 0; pk = 0;
  endtask

  // op: 0 idle, 1 write, 2 read
  task automatic step(input int op, input logic [2:0] a, input logic [31:0] wd);
    logic [W-1:0] g;
    chipselect = (op != 0);
    write_n    = (op != 1);
    address    = a;
    writedata  = wd;
    #2;
    if (op == 2) check_eq($sformatf("rd_a%0d", a), readdata, m_read(a));
    g = m_gated();
    @(posedge clk);
    #1;
    bk++; pk++;
    if (op == 1) begin
      case (a)
        3'd0: m_data = wd[W-1:0];
        3'd1: m_data = m_data | wd[W-1:0];
        3'd2: m_data = m_data & ~wd[W-1:0];
        3'd3: m_mask = wd[W-1:0];
        3'd4: begin m_period = longint'(wd[23:0]); bk = 0; end
`ifdef NIOS2_LED_CTRL_PWM_EN
        3'd5: m_duty = int'(wd[7:0]);
`endif
        default: ;
      endcase
    end
    exp_out = g;
    check_eq("out_port", 32'(out_port), 32'(exp_out));
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_now(input string tag, input logic [2:0] a, input logic [31:0] exp);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
    check_eq(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  initial begin
    int hi;
    int op;
    logic [2:0] a;
    logic [31:0] wd;

    m_reset();
    #12;
    check_eq("rst_out", 32'(out_port), 32'd0);
    read_now("rst_data", 3'd0, 32'(RV));
    read_now("rst_period", 3'd4, 32'd0);
    read_now("rst_status", 3'd6, 32'd3);
`ifdef NIOS2_LED_CTRL_PWM_EN
    read_now("rst_duty", 3'd5, 32'hFF);
`else
    read_now("rst_duty", 3'd5, 32'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    check_eq("rst_rel_out", 32'(out_port), 32'(RV));

    // DATA / SET / CLEAR with readback
    step(1, 3'd0, 32'hFFFF_F0F0);
    step(1, 3'd1, 32'h0000_0003);
    step(2, 3'd0, 0);
    check_eq("set_val", 32'(m_data), 32'h0F3);
    step(1, 3'd2, 32'h0000_0030);
    step(2, 3'd0, 0);
    check_eq("clr_val", 32'(m_data), 32'h0C3);
    step(2, 3'd1, 0);
    step(2, 3'd2, 0);
    step(2, 3'd7, 0);
    step(1, 3'd6, 32'hFFFF_FFFF);
    step(1, 3'd7, 32'hFFFF_FFFF);
    step(0, 0, 0);
    check_eq("out_0c3", 32'(out_port), 32'h0C3);

    // blink on bit 0 with half-period 5
    step(1, 3'd0, 32'h3FF);
    step(1, 3'd3, 32'h001);
    step(1, 3'd4, 32'd4);
    step(0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0);
      check_eq("blink_hi", 32'(out_port[9:1]), 32'h1FF);
    end

    // PERIOD written exactly at terminal count while phase is 1
    step(1, 3'd4, 32'd3);
    for (int i = 0; i < 12 && !((bk % (m_period + 1)) == m_period && m_phase()); i++)
      step(0, 0, 0);
    check_eq("coin_reach", 32'((bk % (m_period + 1)) == m_period && m_phase()), 32'd1);
    step(1, 3'd4, 32'd5);
    read_now("coin_phase", 3'd6, {30'd0, 1'b1, 1'b1});
    step(2, 3'd6, 0);

`ifdef NIOS2_LED_CTRL_PWM_EN
    step(1, 3'd3, 32'h0);
    step(1, 3'd0, 32'h001);
    for (int d = 0; d < 3; d++) begin
      step(1, 3'd5, (d == 0) ? 32'd64 : (d == 1) ? 32'd0 : 32'd255);
      step(0, 0, 0);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
        step(0, 0, 0);
        hi += int'(out_port[0]);
      end
      check_eq($sformatf("pwm_hi_d%0d", d), 32'(hi), (d == 0) ? 32'd64 : (d == 1) ? 32'd0 : 32'd256);
    end
`endif

    // randomized traffic
    for (int i = 0; i < 700; i++) begin
      op = $urandom_range(0, 2);
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd4) wd = ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 6));
      if (a == 3'd5 && $urandom_range(0, 3) == 0) wd = 32'hFF;
      step(op, a, wd);
    end

    // asynchronous reset between edges
    step(1, 3'd0, 32'h3FF);
    step(1, 3'd3, 32'h0);
    step(1, 3'd4, 32'd2);
    step(0, 0, 0);
    step(0, 0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst_out", 32'(out_port), 32'd0);
    m_reset();
    read_now("arst_data", 3'd0, 32'(RV));
    read_now("arst_period", 3'd4, 32'd0);
    read_now("arst_status", 3'd6, 32'd3);
    @(posedge clk);
    #1;
    check_eq("arst_hold", 32'(out_port), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      step(2, 3'd6, 0);
    end
    check_eq("arst_rel_out", 32'(out_port), 32'(RV));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nios2system_led_ctrl.md
Name: nios2system_led_ctrl

Overview:
- Parametrised successor to the system's single-register LED PIO. Avalon-MM slave on the Nios II data master, driving WIDTH output lines.
- Adds atomic set/clear registers and a per-channel blink mask driven by a programmable prescaler.
- Adds a global PWM brightness stage.
- Output is registered and glitch-free for direct pad connection.

Parameters:
- WIDTH, 10, number of output channels (1..32).
- RESET_VALUE, 0, DATA register value after reset (WIDTH bits).
- PRESCALE_W, 24, width of the blink period register/counter (1..32).
- PWM_W, 8, width of the duty register and PWM counter (1..16).

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write is chipselect && !write_n.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address; zero-extended.
- out_port  out  WIDTH  gated, registered output to LEDs.

Behaviour:
- Register map (word addresses):
  - 0 DATA: rw.
  - 1 SET: wo. DATA <= DATA | wd[WIDTH-1:0].
  - 2 CLEAR: wo. DATA <= DATA & ~wd[WIDTH-1:0].
  - 3 BLINK_MASK: rw.
  - 4 PERIOD: rw, PRESCALE_W bits.
  - 5 DUTY: rw, PWM_W bits.
  - 6 STATUS: ro. bit0 = blink_phase, bit1 = pwm_on.
  - 7: reserved.
- Reads of SET, CLEAR and address 7 return 0. Writes to STATUS and address 7 are ignored. Reads have no side effects; no wait states.
- Register writes take effect on the clock edge ending the write cycle. Upper writedata bits are ignored.
- Reset values (asynchronous, on reset_n low):
  - DATA = RESET_VALUE.
  - BLINK_MASK = 0.
  - PERIOD = 0.
  - DUTY = all ones.
  - blink_cnt = 0, blink_phase = 1, pwm_cnt = 0.
  - out_port = 0.
- Blink prescaler:
  - blink_cnt increments every clock.
  - When blink_cnt == PERIOD: blink_cnt <= 0 and blink_phase toggles. The half-period is therefore PERIOD+1 clocks; PERIOD = 0 toggles every clock.
  - A write to PERIOD sets blink_cnt <= 0 and blink_phase <= 1 in the same edge. The write wins over a coincident terminal count.
- PWM:
  - pwm_cnt is a free-running PWM_W-bit counter that wraps from all-ones to 0.
  - pwm_on = (DUTY == all ones) | (pwm_cnt < DUTY).
  - DUTY = 0 gives permanently off. All ones gives permanently on, so the reset default behaves like a plain PIO.
  - DUTY writes do not reset pwm_cnt.
- Output path:
  - gated[i] = DATA[i] & (~BLINK_MASK[i] | blink_phase) & pwm_on.
  - out_port <= gated every clock.
  - Latency: a write in cycle N is visible on out_port after the second rising edge (N+2).
- Reset asserted mid-operation clears all state immediately (asynchronous). The first count starts on the first edge after deassertion.
- Only one register access is possible per cycle, so SET/CLEAR/DATA write conflicts cannot occur.

Optional Feature:
- NIOS2_LED_CTRL_PWM_EN:
  - Defined: DUTY register, pwm_cnt and PWM gating are present, as above.
  - Undefined: no PWM logic is synthesised. pwm_on is constant 1. DUTY reads 0 and writes are ignored. STATUS bit1 reads 1.

Test Plan:
- Reset, no writes, WIDTH = 10 -> out_port = 0x000 during reset. out_port = RESET_VALUE two edges after reset_n rises. DUTY reads 0xFF.
- Write DATA = 0x0F0, then SET = 0x003, then CLEAR = 0x030 -> DATA reads 0x0F3 then 0x0C3. out_port follows each write with 2-cycle latency. SET/CLEAR read 0.
- DATA = 0x3FF, BLINK_MASK = 0x001, PERIOD = 4 -> bit0 holds for 5 clocks and toggles repeatedly. Bits 9..1 stay 1.
- PWM build, DATA = 0x001, DUTY = 64 -> out_port[0] high for exactly 64 of every 256 clocks. DUTY = 0 -> never high. DUTY = 255 -> always high.
- PERIOD written in the same cycle that blink_cnt reaches the old PERIOD -> blink_cnt = 0 and blink_phase = 1 (no toggle). STATUS bit0 reads 1.
- reset_n pulsed low mid-blink, asynchronously between edges -> out_port and counters clear immediately without waiting for clk. Registers return to reset values.
